// File: rtl/rx_pkg.sv
// Shared definitions for the packet receiver and the register/memory dispatch logic.
package rx_pkg;

  // Address-to-ID translation defaults, shared with the dispatch side
  localparam int          ADDR_SHIFT_DEFAULT   = 2;
  localparam int unsigned ADDR_CEILING_DEFAULT = 32'h0000_0FFF;
  localparam int unsigned ID_CEILING_DEFAULT   = 32'h0000_03FF;

  // Word width of the default build, as seen by the dispatch logic
  localparam int DATA_WIDTH_DEFAULT = 64;

  // Queued word plus its early-termination tag (default word width)
  typedef struct packed {
    logic                          short_word;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } rx_word_t;

  // Number of bus beats needed to fill one word (at least one)
  function automatic int beats_f(input int bus, input int data);
    int n;
    n = (data + bus - 1) / bus;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is read straight from the
// storage registers and forced to zero while the FIFO is empty.
module rx_word_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset; emptiness is tracked by count alone
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_word_assembler.sv
// Collects narrow bus beats LSB-first into wide words, optionally translates
// each finished word from a byte address to a memory ID, and queues it.
module axi_word_assembler
  import rx_pkg::*;
#(
  parameter int          BUS_WIDTH    = 32,
  parameter int          DATA_WIDTH   = 64,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          ADDR_SHIFT   = ADDR_SHIFT_DEFAULT,
  parameter int unsigned ADDR_CEILING = ADDR_CEILING_DEFAULT,
  parameter int unsigned ID_CEILING   = ID_CEILING_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BUS_WIDTH-1:0]          pkt,
  input  logic                          pkt_valid,
  input  logic                          pkt_last,
  output logic                          pkt_ready,
  input  logic                          is_addr,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          short_word,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          partial_pending
);

  localparam int BEATS = beats_f(BUS_WIDTH, DATA_WIDTH);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PAD_W = BEATS * BUS_WIDTH;

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [DATA_WIDTH-1:0] CEIL_W    = DATA_WIDTH'(ADDR_CEILING);
  localparam logic [DATA_WIDTH-1:0] ID_W      = DATA_WIDTH'(ID_CEILING);

  typedef struct packed {
    logic                  short_word;
    logic [DATA_WIDTH-1:0] data;
  } word_entry_t;

  logic [CNT_W-1:0]      beat_cnt;
  logic [DATA_WIDTH-1:0] asm_reg;
  logic [DATA_WIDTH-1:0] word_raw;
  logic                  take;
  logic                  complete;
  logic                  fifo_full;
  logic                  fifo_empty;
  int                    shamt;
  word_entry_t           push_entry;
  word_entry_t           head_entry;

  // Ready depends only on the registered fill level; a flush swallows the beat
  assign pkt_ready       = !fifo_full;
  assign take            = pkt_valid && pkt_ready && !flush;
  assign complete        = take && ((beat_cnt == LAST_BEAT) || pkt_last);
  assign partial_pending = (beat_cnt != '0);

  // Merge the current beat into its slice; higher slices are still zero
  // because the assembly register is cleared after every word
  always_comb begin
    shamt      = int'(beat_cnt) * BUS_WIDTH;
    word_raw   = asm_reg | DATA_WIDTH'(PAD_W'(pkt) << shamt);
    push_entry = '0;
    push_entry.short_word = pkt_last && (beat_cnt != LAST_BEAT);
    if (is_addr) begin
      push_entry.data = (word_raw <= CEIL_W) ? (word_raw >> ADDR_SHIFT) : ID_W;
    end else begin
      push_entry.data = word_raw;
    end
  end

  // Beat counter and assembly register; flush and completion both start over
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      beat_cnt <= '0;
      asm_reg  <= '0;
    end else if (complete) begin
      beat_cnt <= '0;
      asm_reg  <= '0;
    end else if (take) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
      asm_reg  <= word_raw;
    end
  end

  rx_word_fifo #(
    .WIDTH ($bits(word_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (complete),
    .pop   (data_valid && data_ready),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign data_valid = !fifo_empty;
  assign data_out   = head_entry.data;
  assign short_word = head_entry.short_word;

endmodule

// File: tb/tb_axi_word_assembler.sv
// Scoreboard bench: two assembler instances (16->48 bit and 32->16 bit),
// expected words queued at issue time and checked by per-instance monitors.
module tb_axi_word_assembler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A: 16-bit beats into 48-bit words (three beats per word)
  logic [15:0] a_pkt;
  logic        a_valid, a_last, a_ready, a_is_addr, a_flush;
  logic [47:0] a_data;
  logic        a_dvalid, a_dready, a_short, a_pend;
  logic [2:0]  a_count;

  // Instance B: 32-bit beats into 16-bit words (one beat per word)
  logic [31:0] b_pkt;
  logic        b_valid, b_last, b_ready, b_is_addr, b_flush;
  logic [15:0] b_data;
  logic        b_dvalid, b_dready, b_short, b_pend;
  logic [2:0]  b_count;

  axi_word_assembler #(
    .BUS_WIDTH (16),
    .DATA_WIDTH(48),
    .FIFO_DEPTH(4)
  ) dut_a (
    .clk            (clk),
    .rst            (rst),
    .pkt            (a_pkt),
    .pkt_valid      (a_valid),
    .pkt_last       (a_last),
    .pkt_ready      (a_ready),
    .is_addr        (a_is_addr),
    .flush          (a_flush),
    .data_out       (a_data),
    .data_valid     (a_dvalid),
    .data_ready     (a_dready),
    .short_word     (a_short),
    .fifo_count     (a_count),
    .partial_pending(a_pend)
  );

  axi_word_assembler #(
    .BUS_WIDTH (32),
    .DATA_WIDTH(16),
    .FIFO_DEPTH(4)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .pkt            (b_pkt),
    .pkt_valid      (b_valid),
    .pkt_last       (b_last),
    .pkt_ready      (b_ready),
    .is_addr        (b_is_addr),
    .flush          (b_flush),
    .data_out       (b_data),
    .data_valid     (b_dvalid),
    .data_ready     (b_dready),
    .short_word     (b_short),
    .fifo_count     (b_count),
    .partial_pending(b_pend)
  );

  typedef struct {
    logic [47:0] data;
    logic        short_word;
  } exp_a_t;

  exp_a_t      q_a[$];
  logic [15:0] q_b[$];
  exp_a_t      mon_a_exp;
  logic [15:0] mon_b_exp;
  int          checks = 0;
  int          errors = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] d, input logic last);
    int waits = 0;
    a_pkt = d; a_valid = 1'b1; a_last = last;
    @(negedge clk);
    while (!a_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!a_ready) check_output("a_send_timeout", 64'(a_ready), 64'd1);
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_last = 1'b0; a_pkt = '0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic addr);
    int waits = 0;
    b_pkt = d; b_valid = 1'b1; b_is_addr = addr;
    @(negedge clk);
    while (!b_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!b_ready) check_output("b_send_timeout", 64'(b_ready), 64'd1);
    @(posedge clk);
    #1;
    b_valid = 1'b0; b_is_addr = 1'b0; b_pkt = '0;
  endtask

  task automatic pulse_ready_a(input int n);
    a_dready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    a_dready = 1'b0;
  endtask

  task automatic pulse_ready_b(input int n);
    b_dready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    b_dready = 1'b0;
  endtask

  // Monitor A: every pop must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && a_dvalid && a_dready) begin
      if (q_a.size() == 0) begin
        check_output("a_unexpected_pop", 64'(a_data), 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        mon_a_exp = q_a.pop_front();
        check_output("a_data", 64'(a_data), 64'(mon_a_exp.data));
        check_output("a_short", 64'(a_short), 64'(mon_a_exp.short_word));
      end
    end
  end

  // Monitor B: every pop must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && b_dvalid && b_dready) begin
      if (q_b.size() == 0) begin
        check_output("b_unexpected_pop", 64'(b_data), 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        mon_b_exp = q_b.pop_front();
        check_output("b_data", 64'(b_data), 64'(mon_b_exp));
        check_output("b_short", 64'(b_short), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_pkt = '0; a_valid = 0; a_last = 0; a_is_addr = 0; a_flush = 0; a_dready = 0;
    b_pkt = '0; b_valid = 0; b_last = 0; b_is_addr = 0; b_flush = 0; b_dready = 0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_output("rst_a_dvalid", 64'(a_dvalid), 64'd0);
    check_output("rst_a_data",   64'(a_data),   64'd0);
    check_output("rst_a_count",  64'(a_count),  64'd0);
    check_output("rst_a_pend",   64'(a_pend),   64'd0);
    check_output("rst_a_short",  64'(a_short),  64'd0);
    check_output("rst_a_ready",  64'(a_ready),  64'd1);
    check_output("rst_b_ready",  64'(b_ready),  64'd1);
    check_output("rst_b_dvalid", 64'(b_dvalid), 64'd0);
    step();

    // Full three-beat word, consumer always ready
    a_dready = 1'b1;
    q_a.push_back('{48'h3333_2222_1111, 1'b0});
    send_a(16'h1111, 1'b0);
    send_a(16'h2222, 1'b0);
    send_a(16'h3333, 1'b0);
    @(negedge clk);
    check_output("a1_latency_dvalid", 64'(a_dvalid), 64'd1);
    step();
    @(negedge clk);
    check_output("a1_popped_dvalid", 64'(a_dvalid), 64'd0);
    step();
    a_dready = 1'b0;

    // Short word ended by pkt_last after two beats
    q_a.push_back('{48'h0000_BBBB_AAAA, 1'b1});
    send_a(16'hAAAA, 1'b0);
    @(negedge clk);
    check_output("a2_pend_mid", 64'(a_pend), 64'd1);
    step();
    send_a(16'hBBBB, 1'b1);
    @(negedge clk);
    check_output("a2_pend_done", 64'(a_pend),   64'd0);
    check_output("a2_dvalid",    64'(a_dvalid), 64'd1);
    check_output("a2_short",     64'(a_short),  64'd1);
    step();
    pulse_ready_a(1);
    @(negedge clk);
    check_output("a2_empty", 64'(a_dvalid), 64'd0);
    step();

    // Flush wins over a beat that would have completed the word
    send_a(16'h1234, 1'b0);
    @(negedge clk);
    check_output("fl_pend_before", 64'(a_pend), 64'd1);
    step();
    a_flush = 1'b1; a_valid = 1'b1; a_pkt = 16'h5555; a_last = 1'b1;
    step();
    a_flush = 1'b0; a_valid = 1'b0; a_pkt = '0; a_last = 1'b0;
    @(negedge clk);
    check_output("fl_pend_after", 64'(a_pend),   64'd0);
    check_output("fl_count",      64'(a_count),  64'd0);
    check_output("fl_dvalid",     64'(a_dvalid), 64'd0);
    step();
    q_a.push_back('{48'h0003_0002_0001, 1'b0});
    send_a(16'h0001, 1'b0);
    send_a(16'h0002, 1'b0);
    send_a(16'h0003, 1'b0);
    @(negedge clk);
    check_output("fl_next_count", 64'(a_count), 64'd1);
    step();
    pulse_ready_a(1);
    @(negedge clk);
    check_output("fl_drained", 64'(a_count), 64'd0);
    step();

    // Reset with two queued words and one partial beat
    for (int i = 0; i < 6; i++) send_a(16'(16'h0010 + i), 1'b0);
    send_a(16'h0099, 1'b0);
    @(negedge clk);
    check_output("rq_count_before", 64'(a_count), 64'd2);
    check_output("rq_pend_before",  64'(a_pend),  64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_output("rq_dvalid", 64'(a_dvalid), 64'd0);
    check_output("rq_count",  64'(a_count),  64'd0);
    check_output("rq_pend",   64'(a_pend),   64'd0);
    check_output("rq_ready",  64'(a_ready),  64'd1);
    check_output("rq_data",   64'(a_data),   64'd0);
    step();

    // Address translation and truncation on the narrow-word instance
    b_dready = 1'b1;
    q_b.push_back(16'h0004);
    send_b(32'h0000_0010, 1'b1);
    q_b.push_back(16'h03FF);
    send_b(32'h0000_2000, 1'b1);
    q_b.push_back(16'h1234);
    send_b(32'hABCD_1234, 1'b0);
    @(negedge clk);
    step();
    step();
    b_dready = 1'b0;
    @(negedge clk);
    check_output("b_addr_drained", 64'(b_count), 64'd0);
    step();

    // Fill the FIFO, hold the fifth beat, release one slot
    for (int i = 0; i < 5; i++) q_b.push_back(16'(16'h0100 + i));
    for (int i = 0; i < 4; i++) send_b(32'(32'h0100 + i), 1'b0);
    @(negedge clk);
    check_output("full_count", 64'(b_count), 64'd4);
    check_output("full_ready", 64'(b_ready), 64'd0);
    step();
    b_pkt = 32'h0000_0104; b_valid = 1'b1;
    @(negedge clk);
    check_output("full_hold_ready", 64'(b_ready), 64'd0);
    step();
    @(negedge clk);
    check_output("full_hold_count", 64'(b_count), 64'd4);
    step();
    b_dready = 1'b1;
    @(negedge clk);
    step();
    b_dready = 1'b0;
    @(negedge clk);
    check_output("full_release_ready", 64'(b_ready), 64'd1);
    check_output("full_release_count", 64'(b_count), 64'd3);
    step();
    b_valid = 1'b0; b_pkt = '0;
    @(negedge clk);
    check_output("full_refill_count", 64'(b_count), 64'd4);
    step();
    pulse_ready_b(4);
    @(negedge clk);
    check_output("end_b_count",  64'(b_count),    64'd0);
    check_output("end_q_b_left", 64'(q_b.size()), 64'd0);
    check_output("end_q_a_left", 64'(q_a.size()), 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
